// File: rtl/fft_dit_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_dit_stage_sequencer_if
//   Groups the control and address signals between the FFT stage sequencer
//   and the butterfly datapath / twiddle ROM that it drives.
//
//   Signals
//     start       request to begin a transform (1-cycle pulse)
//     bf_ready    datapath can accept a butterfly issue this cycle
//     tf_addr     twiddle ROM address (LOG_N-1 bits)
//     tf_addr_nd  twiddle ROM address strobe
//     bf_addr_a   upper butterfly operand address, aligned with ROM output
//     bf_addr_b   lower butterfly operand address
//     bf_nd       butterfly operands and twiddle valid this cycle
//     stage       current stage index
//     busy        transform in progress
//     done        1-cycle completion pulse
//
//   Modports
//     master  the sequencer side (drives addresses and status)
//     slave   the datapath / controller side
// ---------------------------------------------------------------------------
interface fft_dit_stage_sequencer_if #(
  parameter int LOG_N = 4
);
  logic             start;
  logic             bf_ready;
  logic [LOG_N-2:0] tf_addr;
  logic             tf_addr_nd;
  logic [LOG_N-1:0] bf_addr_a;
  logic [LOG_N-1:0] bf_addr_b;
  logic             bf_nd;
  logic [LOG_N-1:0] stage;
  logic             busy;
  logic             done;

  modport master (
    input  start, bf_ready,
    output tf_addr, tf_addr_nd, bf_addr_a, bf_addr_b, bf_nd, stage, busy, done
  );

  modport slave (
    output start, bf_ready,
    input  tf_addr, tf_addr_nd, bf_addr_a, bf_addr_b, bf_nd, stage, busy, done
  );
endinterface

// File: rtl/fft_dit_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_dit_stage_sequencer
//   Sequences one in-place radix-2 decimation-in-time FFT of N points.
//   Walks LOG_N stages of N/2 butterflies each. For every butterfly it
//   issues the twiddle ROM address with its strobe, and one cycle later the
//   two operand addresses with bf_nd, so the addresses line up with the
//   registered ROM output. Between stages the butterfly pipeline is drained
//   for BF_LATENCY cycles so a stage never reads data still being written.
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    master side of fft_dit_stage_sequencer_if
//
//   Parameters
//     N           FFT length (power of two, >= 4)
//     LOG_N       log2(N)
//     BF_LATENCY  butterfly issue-to-writeback latency (drain length)
// ---------------------------------------------------------------------------
module fft_dit_stage_sequencer #(
  parameter int N          = 16,
  parameter int LOG_N      = 4,
  parameter int BF_LATENCY = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  fft_dit_stage_sequencer_if.master       bus
);

  localparam int K_W = LOG_N - 1;
  localparam int S_W = LOG_N;
  localparam int D_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(N / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(LOG_N - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(BF_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [K_W-1:0]   k;
  logic [S_W-1:0]   s;
  logic [D_W-1:0]   drain_cnt;

  logic [K_W-1:0]   tf_addr_q;
  logic             tf_addr_nd_q;
  logic [S_W-1:0]   a_pipe;
  logic [S_W-1:0]   b_pipe;
  logic [S_W-1:0]   bf_addr_a_q;
  logic [S_W-1:0]   bf_addr_b_q;
  logic             bf_nd_q;
  logic             busy_q;
  logic             done_q;

  logic [S_W-1:0]   k_ext;
  logic [S_W-1:0]   span;
  logic [S_W-1:0]   pos;
  logic [S_W-1:0]   grp;
  logic [S_W-1:0]   a_next;
  logic [S_W-1:0]   b_next;
  logic [K_W-1:0]   tf_next;

  // Butterfly k of stage s: groups of 2*span points, the upper half of each
  // group pairs with the lower half. The twiddle index is the position in
  // the group scaled to the N/2-entry ROM; pos < N/2, so narrowing it to
  // K_W bits before the shift loses nothing.
  always_comb begin
    k_ext   = {1'b0, k};
    span    = S_W'(1) << s;
    pos     = k_ext & (span - S_W'(1));
    grp     = k_ext >> s;
    a_next  = (grp << (s + S_W'(1))) | pos;
    b_next  = a_next + span;
    tf_next = K_W'(pos) << (S_LAST - s);
  end

  // Main sequencer. The twiddle strobe is registered at issue; the operand
  // addresses pass through one extra register so they arrive together with
  // the ROM's registered output. Address registers hold when not strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      s            <= '0;
      drain_cnt    <= '0;
      tf_addr_q    <= '0;
      tf_addr_nd_q <= 1'b0;
      a_pipe       <= '0;
      b_pipe       <= '0;
      bf_addr_a_q  <= '0;
      bf_addr_b_q  <= '0;
      bf_nd_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      tf_addr_nd_q <= 1'b0;
      done_q       <= 1'b0;
      bf_nd_q      <= tf_addr_nd_q;
      if (tf_addr_nd_q) begin
        bf_addr_a_q <= a_pipe;
        bf_addr_b_q <= b_pipe;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            s      <= '0;
            k      <= '0;
            busy_q <= 1'b1;
          end
        end

        RUN: begin
          if (bus.bf_ready) begin
            tf_addr_nd_q <= 1'b1;
            tf_addr_q    <= tf_next;
            a_pipe       <= a_next;
            b_pipe       <= b_next;
            if (k == K_LAST) begin
              k         <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end

        // Drain ignores bf_ready: the pipeline empties on its own.
        DRAIN: begin
          if (drain_cnt == D_LAST) begin
            drain_cnt <= '0;
            if (s == S_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              s     <= s + S_W'(1);
              state <= RUN;
            end
          end else begin
            drain_cnt <= drain_cnt + D_W'(1);
          end
        end

        // Start is deliberately not looked at here; it must come again in IDLE.
        DONE: begin
          state <= IDLE;
          s     <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tf_addr    = tf_addr_q;
  assign bus.tf_addr_nd = tf_addr_nd_q;
  assign bus.bf_addr_a  = bf_addr_a_q;
  assign bus.bf_addr_b  = bf_addr_b_q;
  assign bus.bf_nd      = bf_nd_q;
  assign bus.stage      = s;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
